// File: rtl/lsu_dram_axi_slv_if.sv
// LSU <-> DRAM AXI-style channel bundle: AW/W/B write path and AR/R read path.
// master = load/store unit side, slave = DRAM model side.
interface lsu_dram_axi_slv_if;
  // Write address / data / response
  logic [7:0]  lsu_axi_awid;
  logic [9:0]  lsu_axi_awaddr;
  logic [7:0]  lsu_axi_awlen;
  logic [2:0]  lsu_axi_awsize;
  logic [1:0]  lsu_axi_awburst;
  logic [2:0]  lsu_axi_awstr;
  logic        lsu_axi_awvld;
  logic [11:0] lsu_axi_oram_addr;
  logic [63:0] lsu_axi_wdata;
  logic [7:0]  lsu_axi_wstrb;
  logic        lsu_axi_wlast;
  logic        lsu_axi_wvld;
  logic        lsu_axi_brdy;
  logic        axi_lsu_awrdy;
  logic        axi_lsu_wrdy;
  logic        axi_lsu_bid;
  logic [1:0]  axi_lsu_bresp;
  logic        axi_lsu_bvld;
  logic [11:0] axi_lsu_resp_oram_addr;
  // Read address / data
  logic [7:0]  lsu_axi_arid;
  logic [9:0]  lsu_axi_araddr;
  logic [7:0]  lsu_axi_arlen;
  logic [2:0]  lsu_axi_arsize;
  logic [1:0]  lsu_axi_arburst;
  logic [2:0]  lsu_axi_arstr;
  logic [7:0]  lsu_axi_arnum;
  logic        lsu_axi_arvld;
  logic        lsu_axi_rrdy;
  logic        axi_lsu_arrdy;
  logic [7:0]  axi_lsu_rid;
  logic [63:0] axi_lsu_rdata;
  logic [1:0]  axi_lsu_rresp;
  logic        axi_lsu_rlast;
  logic        axi_lsu_rvld;

  modport master (
    output lsu_axi_awid, lsu_axi_awaddr, lsu_axi_awlen, lsu_axi_awsize, lsu_axi_awburst,
           lsu_axi_awstr, lsu_axi_awvld, lsu_axi_oram_addr, lsu_axi_wdata, lsu_axi_wstrb,
           lsu_axi_wlast, lsu_axi_wvld, lsu_axi_brdy, lsu_axi_arid, lsu_axi_araddr,
           lsu_axi_arlen, lsu_axi_arsize, lsu_axi_arburst, lsu_axi_arstr, lsu_axi_arnum,
           lsu_axi_arvld, lsu_axi_rrdy,
    input  axi_lsu_awrdy, axi_lsu_wrdy, axi_lsu_bid, axi_lsu_bresp, axi_lsu_bvld,
           axi_lsu_resp_oram_addr, axi_lsu_arrdy, axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp,
           axi_lsu_rlast, axi_lsu_rvld
  );

  modport slave (
    input  lsu_axi_awid, lsu_axi_awaddr, lsu_axi_awlen, lsu_axi_awsize, lsu_axi_awburst,
           lsu_axi_awstr, lsu_axi_awvld, lsu_axi_oram_addr, lsu_axi_wdata, lsu_axi_wstrb,
           lsu_axi_wlast, lsu_axi_wvld, lsu_axi_brdy, lsu_axi_arid, lsu_axi_araddr,
           lsu_axi_arlen, lsu_axi_arsize, lsu_axi_arburst, lsu_axi_arstr, lsu_axi_arnum,
           lsu_axi_arvld, lsu_axi_rrdy,
    output axi_lsu_awrdy, axi_lsu_wrdy, axi_lsu_bid, axi_lsu_bresp, axi_lsu_bvld,
           axi_lsu_resp_oram_addr, axi_lsu_arrdy, axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp,
           axi_lsu_rlast, axi_lsu_rvld
  );
endinterface

// File: rtl/lsu_dram_axi_slv.sv
// Word-addressed 64-bit DRAM slave with independent strided read and write burst FSMs.
// Optional macro LSU_DRAM_RD_LAT_EN: stretch AR-to-first-R delay to RD_LAT cycles.
module lsu_dram_axi_slv #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 4
) (
  input logic               clk,
  input logic               rst_n,
  lsu_dram_axi_slv_if.slave bus
);

  typedef enum logic [1:0] {RIdle, RWait, RData} r_state_e;
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

  logic [63:0] mem [DEPTH];

  // ---------------- Read channel ----------------
  r_state_e   r_state_q;
  logic [9:0] r_addr_q;
  logic [7:0] r_len_q;
  logic [7:0] r_beat_q;
  logic [2:0] r_str_q;
  logic       r_err_q;
  logic       r_go;
  logic [9:0] r_step;
  logic [63:0] r_word;

  assign r_step = 10'd1 << r_str_q;
  assign r_word = r_err_q ? 64'd0 : mem[r_addr_q];

`ifdef LSU_DRAM_RD_LAT_EN
  logic [3:0] r_lat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lat_q <= 4'd0;
    end else if (r_state_q == RIdle) begin
      r_lat_q <= 4'(RD_LAT - 1);
    end else if (r_state_q == RWait && r_lat_q != 4'd0) begin
      r_lat_q <= r_lat_q - 4'd1;
    end
  end

  assign r_go = (r_lat_q == 4'd0);
`else
  assign r_go = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state_q         <= RIdle;
      r_addr_q          <= 10'd0;
      r_len_q           <= 8'd0;
      r_beat_q          <= 8'd0;
      r_str_q           <= 3'd0;
      r_err_q           <= 1'b0;
      bus.axi_lsu_arrdy <= 1'b1;
      bus.axi_lsu_rid   <= 8'd0;
      bus.axi_lsu_rdata <= 64'd0;
      bus.axi_lsu_rresp <= 2'b00;
      bus.axi_lsu_rlast <= 1'b0;
      bus.axi_lsu_rvld  <= 1'b0;
    end else begin
      case (r_state_q)
        RIdle: begin
          if (bus.lsu_axi_arvld) begin
            bus.axi_lsu_arrdy <= 1'b0;
            bus.axi_lsu_rid   <= bus.lsu_axi_arid;
            r_addr_q          <= bus.lsu_axi_araddr;
            r_len_q           <= bus.lsu_axi_arlen;
            r_str_q           <= bus.lsu_axi_arstr;
            r_err_q           <= (bus.lsu_axi_arsize != 3'd3);
            r_beat_q          <= 8'd0;
            r_state_q         <= RWait;
          end
        end
        RWait: begin
          if (r_go) begin
            bus.axi_lsu_rdata <= r_word;
            bus.axi_lsu_rresp <= r_err_q ? 2'b10 : 2'b00;
            bus.axi_lsu_rvld  <= 1'b1;
            bus.axi_lsu_rlast <= (r_len_q == 8'd0);
            r_beat_q          <= 8'd1;
            r_addr_q          <= r_addr_q + r_step;
            r_state_q         <= RData;
          end
        end
        RData: begin
          if (bus.lsu_axi_rrdy) begin
            if (bus.axi_lsu_rlast) begin
              bus.axi_lsu_rvld  <= 1'b0;
              bus.axi_lsu_rlast <= 1'b0;
              bus.axi_lsu_arrdy <= 1'b1;
              r_state_q         <= RIdle;
            end else begin
              // r_beat_q is the index of the beat being loaded now
              bus.axi_lsu_rdata <= r_word;
              bus.axi_lsu_rlast <= (r_beat_q == r_len_q);
              r_beat_q          <= r_beat_q + 8'd1;
              r_addr_q          <= r_addr_q + r_step;
            end
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  // ---------------- Write channel ----------------
  w_state_e    w_state_q;
  logic [9:0]  w_addr_q;
  logic [7:0]  w_len_q;
  logic [7:0]  w_cnt_q;
  logic        w_over_q;
  logic [2:0]  w_str_q;
  logic        w_err_q;
  logic        w_id_q;
  logic [11:0] w_oram_q;
  logic        mem_we;
  logic        w_len_ok;

  // w_over_q: awlen+1 beats already taken, later beats are dropped
  assign mem_we   = rst_n && (w_state_q == WData) && bus.lsu_axi_wvld && !w_err_q && !w_over_q;
  assign w_len_ok = !w_over_q && (w_cnt_q == w_len_q);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.lsu_axi_wstrb[b]) begin
          mem[w_addr_q][b*8 +: 8] <= bus.lsu_axi_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state_q                  <= WIdle;
      w_addr_q                   <= 10'd0;
      w_len_q                    <= 8'd0;
      w_cnt_q                    <= 8'd0;
      w_over_q                   <= 1'b0;
      w_str_q                    <= 3'd0;
      w_err_q                    <= 1'b0;
      w_id_q                     <= 1'b0;
      w_oram_q                   <= 12'd0;
      bus.axi_lsu_awrdy          <= 1'b1;
      bus.axi_lsu_wrdy           <= 1'b0;
      bus.axi_lsu_bid            <= 1'b0;
      bus.axi_lsu_bresp          <= 2'b00;
      bus.axi_lsu_bvld           <= 1'b0;
      bus.axi_lsu_resp_oram_addr <= 12'd0;
    end else begin
      case (w_state_q)
        WIdle: begin
          if (bus.lsu_axi_awvld) begin
            bus.axi_lsu_awrdy <= 1'b0;
            bus.axi_lsu_wrdy  <= 1'b1;
            w_id_q            <= bus.lsu_axi_awid[0];
            w_addr_q          <= bus.lsu_axi_awaddr;
            w_len_q           <= bus.lsu_axi_awlen;
            w_str_q           <= bus.lsu_axi_awstr;
            w_oram_q          <= bus.lsu_axi_oram_addr;
            w_err_q           <= (bus.lsu_axi_awsize != 3'd3);
            w_cnt_q           <= 8'd0;
            w_over_q          <= 1'b0;
            w_state_q         <= WData;
          end
        end
        WData: begin
          if (bus.lsu_axi_wvld) begin
            w_addr_q <= w_addr_q + (10'd1 << w_str_q);
            if (!w_over_q) begin
              if (w_cnt_q == w_len_q) w_over_q <= 1'b1;
              else                    w_cnt_q  <= w_cnt_q + 8'd1;
            end
            if (bus.lsu_axi_wlast) begin
              bus.axi_lsu_wrdy           <= 1'b0;
              bus.axi_lsu_bvld           <= 1'b1;
              bus.axi_lsu_bid            <= w_id_q;
              bus.axi_lsu_resp_oram_addr <= w_oram_q;
              bus.axi_lsu_bresp          <= (w_err_q || !w_len_ok) ? 2'b10 : 2'b00;
              w_state_q                  <= WResp;
            end
          end
        end
        WResp: begin
          if (bus.lsu_axi_brdy) begin
            bus.axi_lsu_bvld  <= 1'b0;
            bus.axi_lsu_awrdy <= 1'b1;
            w_state_q         <= WIdle;
          end
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  // Inputs the protocol carries but this slave does not act on
  logic unused_in;
  assign unused_in = ^{bus.lsu_axi_awid[7:1], bus.lsu_axi_awburst, bus.lsu_axi_arburst,
                       bus.lsu_axi_arnum, 4'(RD_LAT)};

endmodule

// File: tb/tb_lsu_dram_axi_slv.sv
// Directed bench for lsu_dram_axi_slv: reference memory model plus R/B scoreboards.
module tb_lsu_dram_axi_slv;
  localparam int unsigned RdLat = 4;
`ifdef LSU_DRAM_RD_LAT_EN
  localparam int ExpWait = RdLat;
`else
  localparam int ExpWait = 1;
`endif

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [1:0]  resp;
    logic [7:0]  id;
  } rbeat_t;

  typedef struct packed {
    logic        bid;
    logic [1:0]  bresp;
    logic [11:0] oram;
  } bexp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_dram_axi_slv_if bus ();

  lsu_dram_axi_slv #(.DEPTH(1024), .RD_LAT(RdLat)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  rbeat_t      r_q[$];
  bexp_t       b_q[$];
  logic [63:0] mdl [1024];
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Expected read beats from the current model state
  task automatic exp_read(input logic [9:0] addr, input logic [7:0] len, input logic [2:0] str,
                          input logic [2:0] size, input logic [7:0] id);
    logic [9:0] a;
    rbeat_t e;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      e.data = (size == 3'd3) ? mdl[a] : 64'd0;
      e.last = (i == int'(len));
      e.resp = (size == 3'd3) ? 2'b00 : 2'b10;
      e.id   = id;
      r_q.push_back(e);
      a = a + (10'd1 << str);
    end
  endtask

  task automatic read_burst(input logic [9:0] addr, input logic [7:0] len, input logic [2:0] str,
                            input logic [2:0] size, input logic [7:0] id,
                            input int stall_beat, input int stall_cyc);
    int wait_n;
    rbeat_t e;
    @(negedge clk);
    check("arrdy_idle", 64'(bus.axi_lsu_arrdy), 64'd1);
    bus.lsu_axi_araddr = addr;
    bus.lsu_axi_arlen  = len;
    bus.lsu_axi_arstr  = str;
    bus.lsu_axi_arsize = size;
    bus.lsu_axi_arid   = id;
    bus.lsu_axi_arvld  = 1'b1;
    bus.lsu_axi_rrdy   = 1'b1;
    @(negedge clk);
    bus.lsu_axi_arvld = 1'b0;
    check("arrdy_busy", 64'(bus.axi_lsu_arrdy), 64'd0);
    wait_n = 0;
    while (!bus.axi_lsu_rvld && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    check("rd_latency", 64'(wait_n), 64'(ExpWait));
    for (int i = 0; i <= int'(len); i++) begin
      check("rvld", 64'(bus.axi_lsu_rvld), 64'd1);
      if (r_q.size() == 0) begin
        check("r_q_empty", 64'(r_q.size()), 64'd1);
        return;
      end
      e = r_q[0];
      if (i == stall_beat) begin
        bus.lsu_axi_rrdy = 1'b0;
        for (int c = 0; c < stall_cyc; c++) begin
          @(negedge clk);
          check("stall_rvld", 64'(bus.axi_lsu_rvld), 64'd1);
          check("stall_rdata", bus.axi_lsu_rdata, e.data);
        end
        bus.lsu_axi_rrdy = 1'b1;
      end
      e = r_q.pop_front();
      check("rdata", bus.axi_lsu_rdata, e.data);
      check("rlast", 64'(bus.axi_lsu_rlast), 64'(e.last));
      check("rresp", 64'(bus.axi_lsu_rresp), 64'(e.resp));
      check("rid", 64'(bus.axi_lsu_rid), 64'(e.id));
      @(negedge clk);
    end
    check("rvld_done", 64'(bus.axi_lsu_rvld), 64'd0);
    check("arrdy_done", 64'(bus.axi_lsu_arrdy), 64'd1);
  endtask

  task automatic write_burst(input logic [9:0] addr, input logic [7:0] len, input logic [2:0] str,
                             input logic [2:0] size, input logic [7:0] id, input logic [11:0] oram,
                             input int nbeats, input logic [63:0] d0, input logic [63:0] dinc,
                             input logic [7:0] strb0, input logic [7:0] strb);
    logic [9:0]  a;
    logic [63:0] d;
    logic [7:0]  s;
    bexp_t       e;
    a = addr;
    @(negedge clk);
    check("awrdy_idle", 64'(bus.axi_lsu_awrdy), 64'd1);
    bus.lsu_axi_awaddr    = addr;
    bus.lsu_axi_awlen     = len;
    bus.lsu_axi_awstr     = str;
    bus.lsu_axi_awsize    = size;
    bus.lsu_axi_awid      = id;
    bus.lsu_axi_oram_addr = oram;
    bus.lsu_axi_awvld     = 1'b1;
    @(negedge clk);
    bus.lsu_axi_awvld = 1'b0;
    check("wrdy", 64'(bus.axi_lsu_wrdy), 64'd1);
    for (int k = 0; k < nbeats; k++) begin
      d = d0 + 64'(k) * dinc;
      s = (k == 0) ? strb0 : strb;
      bus.lsu_axi_wdata = d;
      bus.lsu_axi_wstrb = s;
      bus.lsu_axi_wlast = (k == nbeats - 1);
      bus.lsu_axi_wvld  = 1'b1;
      if (k <= int'(len) && size == 3'd3) begin
        for (int b = 0; b < 8; b++) if (s[b]) mdl[a][b*8 +: 8] = d[b*8 +: 8];
      end
      a = a + (10'd1 << str);
      @(negedge clk);
    end
    bus.lsu_axi_wvld  = 1'b0;
    bus.lsu_axi_wlast = 1'b0;
    e.bid   = id[0];
    e.bresp = (size != 3'd3 || nbeats != int'(len) + 1) ? 2'b10 : 2'b00;
    e.oram  = oram;
    b_q.push_back(e);
    check("bvld", 64'(bus.axi_lsu_bvld), 64'd1);
    e = b_q.pop_front();
    check("bid", 64'(bus.axi_lsu_bid), 64'(e.bid));
    check("bresp", 64'(bus.axi_lsu_bresp), 64'(e.bresp));
    check("resp_oram", 64'(bus.axi_lsu_resp_oram_addr), 64'(e.oram));
    bus.lsu_axi_brdy = 1'b1;
    @(negedge clk);
    bus.lsu_axi_brdy = 1'b0;
    check("bvld_done", 64'(bus.axi_lsu_bvld), 64'd0);
    check("awrdy_done", 64'(bus.axi_lsu_awrdy), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 64'({bus.axi_lsu_arrdy, bus.axi_lsu_awrdy, bus.axi_lsu_wrdy,
                              bus.axi_lsu_bvld, bus.axi_lsu_rvld, bus.axi_lsu_rlast}), 64'b110000);
    check({tag, "_ids"}, 64'({bus.axi_lsu_rid, bus.axi_lsu_bid, bus.axi_lsu_bresp,
                             bus.axi_lsu_rresp, bus.axi_lsu_resp_oram_addr}), 64'd0);
    check({tag, "_rdata"}, bus.axi_lsu_rdata, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wait_n;
    rbeat_t e;
    bus.lsu_axi_awid = '0; bus.lsu_axi_awaddr = '0; bus.lsu_axi_awlen = '0;
    bus.lsu_axi_awsize = '0; bus.lsu_axi_awburst = 2'b01; bus.lsu_axi_awstr = '0;
    bus.lsu_axi_awvld = 1'b0; bus.lsu_axi_oram_addr = '0; bus.lsu_axi_wdata = '0;
    bus.lsu_axi_wstrb = '0; bus.lsu_axi_wlast = 1'b0; bus.lsu_axi_wvld = 1'b0;
    bus.lsu_axi_brdy = 1'b0; bus.lsu_axi_arid = '0; bus.lsu_axi_araddr = '0;
    bus.lsu_axi_arlen = '0; bus.lsu_axi_arsize = '0; bus.lsu_axi_arburst = 2'b01;
    bus.lsu_axi_arstr = '0; bus.lsu_axi_arnum = 8'h5; bus.lsu_axi_arvld = 1'b0;
    bus.lsu_axi_rrdy = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Preload mem[i] = i through four full-length bursts
    for (int k = 0; k < 4; k++) begin
      write_burst(10'(k * 256), 8'd255, 3'd0, 3'd3, 8'(k), 12'(k), 256, 64'(k * 256), 64'd1,
                  8'hFF, 8'hFF);
    end

    // Basic read
    exp_read(10'd5, 8'd3, 3'd0, 3'd3, 8'h12);
    read_burst(10'd5, 8'd3, 3'd0, 3'd3, 8'h12, -1, 0);

    // Strided wrap: 1020, 0, 4 with a 3-cycle stall on the second beat
    exp_read(10'd1020, 8'd2, 3'd2, 3'd3, 8'h34);
    read_burst(10'd1020, 8'd2, 3'd2, 3'd3, 8'h34, 1, 3);

    // Partial strobe write, then read back
    write_burst(10'd10, 8'd1, 3'd0, 3'd3, 8'h07, 12'hABC, 2, 64'hFFEE_DDCC_BBAA_9988,
                64'h0101_0101_0101_0101, 8'h0F, 8'hFF);
    exp_read(10'd10, 8'd1, 3'd0, 3'd3, 8'h01);
    read_burst(10'd10, 8'd1, 3'd0, 3'd3, 8'h01, -1, 0);

    // Early wlast, size error, and overrun bursts
    write_burst(10'd20, 8'd3, 3'd0, 3'd3, 8'h03, 12'h123, 2, 64'hCAFE_0000_0000_0000, 64'd1,
                8'hFF, 8'hFF);
    write_burst(10'd30, 8'd1, 3'd0, 3'd2, 8'h02, 12'h456, 2, 64'hDEAD_0000_0000_0000, 64'd1,
                8'hFF, 8'hFF);
    write_burst(10'd40, 8'd0, 3'd1, 3'd3, 8'h05, 12'h789, 3, 64'hBEEF_0000_0000_0000, 64'd1,
                8'hFF, 8'hFF);
    exp_read(10'd20, 8'd23, 3'd0, 3'd3, 8'h44);
    read_burst(10'd20, 8'd23, 3'd0, 3'd3, 8'h44, -1, 0);

    // Read with bad size: zero data and SLVERR on every beat
    exp_read(10'd50, 8'd1, 3'd0, 3'd2, 8'h5A);
    read_burst(10'd50, 8'd1, 3'd0, 3'd2, 8'h5A, -1, 0);

    // Concurrent read and write over words 100..115; with a one-cycle wait each read beat
    // collides with the write of the same word and must see the old data.
    for (int i = 0; i < 16; i++) begin
      e.data = (ExpWait == 1) ? mdl[100 + i] : (64'hA5A5_0000_0000_0000 + 64'(i));
      e.last = (i == 15);
      e.resp = 2'b00;
      e.id   = 8'h77;
      r_q.push_back(e);
    end
    fork
      read_burst(10'd100, 8'd15, 3'd0, 3'd3, 8'h77, -1, 0);
      write_burst(10'd100, 8'd15, 3'd0, 3'd3, 8'h09, 12'h3C3, 16, 64'hA5A5_0000_0000_0000,
                  64'd1, 8'hFF, 8'hFF);
    join
    exp_read(10'd100, 8'd15, 3'd0, 3'd3, 8'h78);
    read_burst(10'd100, 8'd15, 3'd0, 3'd3, 8'h78, -1, 0);

    // Reset while the second read beat is presented
    @(negedge clk);
    bus.lsu_axi_araddr = 10'd0;
    bus.lsu_axi_arlen  = 8'd3;
    bus.lsu_axi_arstr  = 3'd0;
    bus.lsu_axi_arsize = 3'd3;
    bus.lsu_axi_arid   = 8'h99;
    bus.lsu_axi_arvld  = 1'b1;
    bus.lsu_axi_rrdy   = 1'b1;
    @(negedge clk);
    bus.lsu_axi_arvld = 1'b0;
    wait_n = 0;
    while (!bus.axi_lsu_rvld && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    check("rst_first_beat", bus.axi_lsu_rdata, mdl[0]);
    @(negedge clk);
    check("rst_second_beat", bus.axi_lsu_rdata, mdl[1]);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;

    // Memory survives reset
    exp_read(10'd10, 8'd1, 3'd0, 3'd3, 8'h21);
    read_burst(10'd10, 8'd1, 3'd0, 3'd3, 8'h21, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
